// File: rtl/mem_l2_pkg.sv
// Shared widths, state encoding and address helper for the L2 memory responder.
package mem_l2_pkg;

    localparam int unsigned TAG_W   = 18;
    localparam int unsigned INDEX_W = 8;
    localparam int unsigned LINE_W  = 512;
    localparam int unsigned ADDR_W  = TAG_W + INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_W,
        WAIT_R,
        RESP,
        DONE
    } state_e;

    // Full line address as seen by the L2: {tag, index}
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                    input logic [INDEX_W-1:0] idx);
        return {tag, idx};
    endfunction

endpackage

// File: rtl/mem_l2_line_store.sv
// Line array with per-line valid bits and a registered, zero-for-invalid read port.
module mem_l2_line_store
    import mem_l2_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [LINE_W-1:0]     wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [LINE_W-1:0]     rdata_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [LINE_W-1:0] rdata_q;

    // Line data: synchronous write, contents survive reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Valid bits: cleared by reset, set by any write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[waddr_i] <= 1'b1;
        end
    end

    // Registered read; a write to the line being read is forwarded so the
    // following cycle already sees the new line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else if (valid_q[raddr_i]) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_l2_responder.sv
// Memory-side slave for the L2: fixed-latency line reads/writes with a one-cycle ready pulse.
module mem_l2_responder
    import mem_l2_pkg::*;
#(
    parameter int unsigned LAT        = 4,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read_L2_MEM,
    input  logic               write_L2_MEM,
    input  logic [TAG_W-1:0]   tag_L2_MEM,
    input  logic [TAG_W-1:0]   write_tag_L2_MEM,
    input  logic [INDEX_W-1:0] index_L2_MEM,
    input  logic [LINE_W-1:0]  write_data_L2_MEM,
    output logic               ready_MEM_L2,
    output logic [LINE_W-1:0]  read_data_MEM_L2
);

    localparam logic [3:0] CNT_RELOAD = 4'(LAT - 1);

    state_e             state_q;
    logic [3:0]         cnt_q;
    logic               pend_rd_q;
    logic               ready_q;
    logic [LINE_W-1:0]  rdata_q;

    logic [TAG_W-1:0]   rtag_q, rtag_d;
    logic [TAG_W-1:0]   wtag_q, wtag_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;

    logic [ADDR_W-1:0]  raddr_full;
    logic [ADDR_W-1:0]  waddr_full;
    logic               store_we;
    logic [LINE_W-1:0]  store_rdata;
    logic               unused_addr_hi;

    // Capture of request fields, only while IDLE
    always_comb begin
        rtag_d  = rtag_q;
        wtag_d  = wtag_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        if (state_q == IDLE) begin
            if (write_L2_MEM) begin
                wtag_d  = write_tag_L2_MEM;
                rtag_d  = tag_L2_MEM;
                idx_d   = index_L2_MEM;
                wdata_d = write_data_L2_MEM;
            end else if (read_L2_MEM) begin
                rtag_d  = tag_L2_MEM;
                idx_d   = index_L2_MEM;
            end
        end
    end

    // Capture registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rtag_q  <= '0;
            wtag_q  <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            rtag_q  <= rtag_d;
            wtag_q  <= wtag_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    // The store reads from the next-state read address so its registered
    // output is already current at the terminal WAIT_R edge, even for LAT=1
    assign raddr_full     = line_addr(rtag_d, idx_d);
    assign waddr_full     = line_addr(wtag_q, idx_q);
    assign store_we       = (state_q == WAIT_W) && (cnt_q == '0);
    assign unused_addr_hi = ^{raddr_full[ADDR_W-1:DEPTH_LOG2], waddr_full[ADDR_W-1:DEPTH_LOG2]};

    mem_l2_line_store #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .we_i    (store_we),
        .waddr_i (waddr_full[DEPTH_LOG2-1:0]),
        .wdata_i (wdata_q),
        .raddr_i (raddr_full[DEPTH_LOG2-1:0]),
        .rdata_o (store_rdata)
    );

    // Request sequencing, latency counting and registered response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_rd_q <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (write_L2_MEM) begin
                        pend_rd_q <= read_L2_MEM;
                        cnt_q     <= CNT_RELOAD;
                        state_q   <= WAIT_W;
                    end else if (read_L2_MEM) begin
                        pend_rd_q <= 1'b0;
                        cnt_q     <= CNT_RELOAD;
                        state_q   <= WAIT_R;
                    end
                end
                WAIT_W: begin
                    if (cnt_q == '0) begin
                        if (pend_rd_q) begin
                            pend_rd_q <= 1'b0;
                            cnt_q     <= CNT_RELOAD;
                            state_q   <= WAIT_R;
                        end else begin
                            ready_q <= 1'b1;
                            state_q <= RESP;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WAIT_R: begin
                    if (cnt_q == '0) begin
                        rdata_q <= store_rdata;
                        ready_q <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_MEM_L2     = ready_q;
    assign read_data_MEM_L2 = rdata_q;

endmodule

// File: tb/tb_mem_l2_responder.sv
// Directed self-checking bench for mem_l2_responder (LAT=4 and LAT=1 instances).
module tb_mem_l2_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         read_L2_MEM;
    logic         write_L2_MEM;
    logic [17:0]  tag_L2_MEM;
    logic [17:0]  write_tag_L2_MEM;
    logic [7:0]   index_L2_MEM;
    logic [511:0] write_data_L2_MEM;

    logic         ready4, ready1;
    logic [511:0] rdata4, rdata1;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    localparam logic [511:0] D_BEEF = {16{32'hDEADBEEF}};
    localparam logic [511:0] D_A    = {16{32'hA5A50001}};
    localparam logic [511:0] D_B    = {16{32'h5A5A0002}};
    localparam logic [511:0] D_C    = {16{32'h0000C0DE}};
    localparam logic [511:0] D_D    = {16{32'hFFFF0D0D}};
    localparam logic [511:0] D_E    = {16{32'h12345678}};

    always #5 clk = ~clk;

    mem_l2_responder #(
        .LAT        (4),
        .DEPTH_LOG2 (10)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .read_L2_MEM       (read_L2_MEM),
        .write_L2_MEM      (write_L2_MEM),
        .tag_L2_MEM        (tag_L2_MEM),
        .write_tag_L2_MEM  (write_tag_L2_MEM),
        .index_L2_MEM      (index_L2_MEM),
        .write_data_L2_MEM (write_data_L2_MEM),
        .ready_MEM_L2      (ready4),
        .read_data_MEM_L2  (rdata4)
    );

    mem_l2_responder #(
        .LAT        (1),
        .DEPTH_LOG2 (10)
    ) u_dut_lat1 (
        .clk               (clk),
        .rst               (rst),
        .read_L2_MEM       (read_L2_MEM),
        .write_L2_MEM      (write_L2_MEM),
        .tag_L2_MEM        (tag_L2_MEM),
        .write_tag_L2_MEM  (write_tag_L2_MEM),
        .index_L2_MEM      (index_L2_MEM),
        .write_data_L2_MEM (write_data_L2_MEM),
        .ready_MEM_L2      (ready1),
        .read_data_MEM_L2  (rdata1)
    );

    task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Drive one request at a negedge, wait for ready on the chosen instance.
    // k counts edges from the accepting edge E0 up to the edge at which the
    // L2 sees ready high, so a single op at LAT=4 gives k=5.
    task automatic run_op(input string name, input logic w, input logic r,
                          input logic [17:0] wt, input logic [17:0] rt, input logic [7:0] ix,
                          input logic [511:0] wd, input logic sel1, input int unsigned exp_k,
                          input logic chk_d, input logic [511:0] exp_d, input logic drop);
        int unsigned k;
        logic        seen;
        k    = 0;
        seen = 1'b0;
        @(negedge clk);
        write_L2_MEM      = w;
        read_L2_MEM       = r;
        write_tag_L2_MEM  = wt;
        tag_L2_MEM        = rt;
        index_L2_MEM      = ix;
        write_data_L2_MEM = wd;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            seen = sel1 ? ready1 : ready4;
        end
        chk({name, "_lat"}, 512'(k), 512'(exp_k));
        if (chk_d) chk({name, "_data"}, sel1 ? rdata1 : rdata4, exp_d);
        if (drop) begin
            write_L2_MEM = 1'b0;
            read_L2_MEM  = 1'b0;
            @(negedge clk);
            chk({name, "_onepulse"}, 512'(sel1 ? ready1 : ready4), 512'(0));
        end
    endtask

    initial begin
        int unsigned g;
        int unsigned pulses;

        rst               = 1'b1;
        read_L2_MEM       = 1'b0;
        write_L2_MEM      = 1'b0;
        tag_L2_MEM        = '0;
        write_tag_L2_MEM  = '0;
        index_L2_MEM      = '0;
        write_data_L2_MEM = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready4", 512'(ready4), 512'(0));
        chk("rst_rdata4", rdata4, '0);
        chk("rst_ready1", 512'(ready1), 512'(0));
        chk("rst_rdata1", rdata1, '0);
        rst = 1'b0;

        // Read of a never-written line returns zero
        run_op("rd_invalid", 1'b0, 1'b1, 18'h0, 18'h00001, 8'h05, '0, 1'b0, 5, 1'b1, '0, 1'b1);

        // Write then read back; read_data holds its old value across the write
        run_op("wr_beef", 1'b1, 1'b0, 18'h00001, 18'h00001, 8'h05, D_BEEF, 1'b0, 5, 1'b1, '0, 1'b1);
        run_op("rd_beef", 1'b0, 1'b1, 18'h0, 18'h00001, 8'h05, '0, 1'b0, 5, 1'b1, D_BEEF, 1'b1);

        // Tag 0x5 aliases tag 0x1 in a 1024-line store (only tag[1:0] kept)
        run_op("rd_alias", 1'b0, 1'b1, 18'h0, 18'h00005, 8'h05, '0, 1'b0, 5, 1'b1, D_BEEF, 1'b1);

        // Combined: write another line, read the earlier one -> one pulse at 2*LAT+1
        run_op("comb_diff", 1'b1, 1'b1, 18'h00002, 18'h00001, 8'h05, D_A, 1'b0, 9, 1'b1, D_BEEF, 1'b1);
        run_op("rd_comb_w", 1'b0, 1'b1, 18'h0, 18'h00002, 8'h05, '0, 1'b0, 5, 1'b1, D_A, 1'b1);

        // Combined to a previously invalid line: read sees the just-written data
        run_op("comb_same", 1'b1, 1'b1, 18'h00003, 18'h00003, 8'h09, D_B, 1'b0, 9, 1'b1, D_B, 1'b1);

        // Read held through RESP/DONE: ready low in DONE and IDLE, then the
        // held request is taken in IDLE and completes LAT+3 cycles later
        run_op("held1", 1'b0, 1'b1, 18'h0, 18'h00001, 8'h05, '0, 1'b0, 5, 1'b1, D_BEEF, 1'b0);
        g = 0;
        @(negedge clk);
        g++;
        chk("held_done_low", 512'(ready4), 512'(0));
        while (!ready4 && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("held_gap", 512'(g), 512'(7));
        chk("held2_data", rdata4, D_BEEF);
        read_L2_MEM = 1'b0;
        @(negedge clk);
        chk("held2_onepulse", 512'(ready4), 512'(0));

        // Reset in the middle of a write: no pulse, nothing committed
        @(negedge clk);
        write_L2_MEM      = 1'b1;
        write_tag_L2_MEM  = 18'h00004;
        tag_L2_MEM        = 18'h00004;
        index_L2_MEM      = 8'h20;
        write_data_L2_MEM = D_E;
        @(negedge clk);
        @(negedge clk);
        rst          = 1'b1;
        write_L2_MEM = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready4) pulses++;
        end
        chk("rst_mid_nopulse", 512'(pulses), 512'(0));
        chk("rst_mid_rdata", rdata4, '0);
        run_op("rd_after_rst", 1'b0, 1'b1, 18'h0, 18'h00004, 8'h20, '0, 1'b0, 5, 1'b1, '0, 1'b1);
        // Line written before reset keeps data but loses its valid bit
        run_op("rd_cleared", 1'b0, 1'b1, 18'h0, 18'h00001, 8'h05, '0, 1'b0, 5, 1'b1, '0, 1'b1);

        // LAT=1 instance: lines 0x000 and 0x3FF, each op completes at E0+2
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_op("l1_w000", 1'b1, 1'b0, 18'h00000, 18'h00000, 8'h00, D_C, 1'b1, 2, 1'b1, '0, 1'b1);
        run_op("l1_w3ff", 1'b1, 1'b0, 18'h00003, 18'h00003, 8'hFF, D_D, 1'b1, 2, 1'b1, '0, 1'b1);
        run_op("l1_r000", 1'b0, 1'b1, 18'h0, 18'h00000, 8'h00, '0, 1'b1, 2, 1'b1, D_C, 1'b1);
        @(negedge clk);
        chk("l1_hold", rdata1, D_C);
        run_op("l1_r3ff", 1'b0, 1'b1, 18'h0, 18'h00003, 8'hFF, '0, 1'b1, 2, 1'b1, D_D, 1'b1);
        run_op("l1_comb", 1'b1, 1'b1, 18'h00001, 18'h00001, 8'h00, D_E, 1'b1, 3, 1'b1, D_E, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
